uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_master transmitter among NUM_REQ byte requesters using round-robin arbitration.
- Accepts one byte per grant and drives the transmitter's data/en_tx inputs.
- Holds en_tx until u_tx_done is seen, then enforces an inter-frame gap before the next grant.
- Sits between on-chip byte producers and the uart_master instance. A watchdog recovers from a transmitter that never completes.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width per request.
- GAP_CYCLES, 16, minimum clk cycles between en_tx deassertion and the next grant (>=1).
- TIMEOUT_CYCLES, 65535, clk cycles in SEND without done before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester byte pending.
- req_data  in  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot accept; transfer occurs when req_valid[i] & req_ready[i].
- tx_data  out  DATA_W  to uart_master data.
- tx_en  out  1  to uart_master en_tx.
- tx_done  in  1  from uart_master u_tx_done; level, may stay high while tx_en is high.
- grant_id  out  $clog2(NUM_REQ)  index of the requester currently being served.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE; tx_en=0; tx_data=0; grant_id=0; timeout_err=0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
  - All counters cleared; done_q=0.
  - req_ready=0 while rst is high.
- Reset mid-SEND drops tx_en on the next edge. The in-flight byte is lost and no error pulse is issued.
- Edge detect: done_q registers tx_done every cycle; done_rise = tx_done & ~done_q.
- IDLE:
  - req_ready is combinational and one-hot for the winner: the first i with req_valid set, searching from last_grant+1 upward with wrap modulo NUM_REQ.
  - All req_ready bits are 0 if no req_valid is set.
  - On the accepting edge: latch tx_data=req_data[winner], grant_id=winner, last_grant=winner, clear wd_cnt, go to SEND.
  - tx_en rises the cycle after acceptance, so grant-to-en_tx latency is 1 clk.
- SEND:
  - tx_en=1; tx_data held stable; req_ready all 0; wd_cnt increments.
  - On done_rise: go to GAP. tx_en is 0 from the next cycle.
  - If wd_cnt==TIMEOUT_CYCLES-1 with no done_rise: pulse timeout_err for 1 cycle, go to GAP (tx_en drops).
  - If done_rise and the timeout coincide, done wins and there is no error pulse.
- GAP:
  - tx_en=0; gap_cnt counts only while tx_done is low.
  - Exit to IDLE when gap_cnt==GAP_CYCLES-1 and tx_done is low.
  - A stuck-high tx_done therefore holds the block in GAP indefinitely (busy=1).
- Requester protocol:
  - Once req_valid is raised, req_data must be stable until accepted.
  - Dropping req_valid before acceptance is legal and simply withdraws the request.
- Fairness: a requester that has just been served cannot win again while another requester has valid set. The worst-case wait is NUM_REQ-1 frames.
- Simultaneous events: a new req_valid arriving during SEND/GAP is not sampled until IDLE. Arbitration uses the req_valid values present in the IDLE cycle.
- grant_id holds its last value through GAP and IDLE until the next acceptance.
- Counter widths: wd_cnt is $clog2(TIMEOUT_CYCLES+1) bits; gap_cnt is $clog2(GAP_CYCLES+1) bits; neither wraps because both are cleared on state entry.

Decomposition:
- Package uart_arb_pkg:
  - state enum {IDLE, SEND, GAP}.
  - Default DATA_W constant.
  - Function rr_pick(valid, last) returning the winner index and a found flag.
- One sub-module, uart_rr_arbiter: combinational round-robin picker (inputs valid and last_grant; outputs one-hot grant and index), reusable for an RX-side scheduler.
- Sequencing FSM, counters and edge detect live in uart_tx_arbiter.

Test Plan:
- Single request: req_valid[2]=1, data 8'h95, model done after 500 cycles
  -> req_ready[2] for 1 cycle; tx_en high next cycle with tx_data=8'h95, grant_id=2; tx_en low the cycle after done_rise; next grant no earlier than 16 cycles after done falls.
- Round-robin: all four valid continuously with data 8'h10..8'h13
  -> service order 0,1,2,3,0; tx_data sequence 10,11,12,13,10.
- Fairness after wrap: last_grant=3, valid on 1 and 3
  -> grant 1, then 3, then 1.
- Timeout: TIMEOUT_CYCLES=100, tx_done held low
  -> tx_en high exactly 100 cycles; timeout_err pulses once; block returns to IDLE after GAP.
- Sticky done: tx_done high from SEND entry (uart_master style) and stays high 40 cycles after tx_en drops
  -> exactly one frame counted; IDLE only after done low plus 16 cycles.
- Reset mid-SEND: assert rst 50 cycles into SEND
  -> tx_en=0, busy=0, grant_id=0 after that edge; no timeout_err; requester 0 wins first after rst deasserts.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its round-robin picker.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_W = 8;

    // Widest requester set the picker supports; narrower sets are zero-extended.
    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = 3;

    typedef struct packed {
        logic        found;
        logic [31:0] idx;
    } pick_t;

    // Round-robin search: first set bit of valid starting just after last,
    // wrapping modulo num. found is clear when no bit in [0, num) is set.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   valid,
                                      input logic [MAX_IDX_W-1:0] last,
                                      input int                   num);
        pick_t res;
        int    cand;
        res.found = 1'b0;
        res.idx   = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            cand = (int'(last) + k) % num;
            if (k <= num && !res.found && valid[cand]) begin
                res.found = 1'b1;
                res.idx   = 32'(cand);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester handshake, transmitter drive and status signals of the arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = uart_arb_pkg::DEFAULT_DATA_W
) ();
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_en;
    logic                      tx_done;
    logic [IDX_W-1:0]          grant_id;
    logic                      busy;
    logic                      timeout_err;

    // Arbiter side.
    modport slave (
        input  req_valid, req_data, tx_done,
        output req_ready, tx_data, tx_en, grant_id, busy, timeout_err
    );

    // Producers plus transmitter side.
    modport master (
        output req_valid, req_data, tx_done,
        input  req_ready, tx_data, tx_en, grant_id, busy, timeout_err
    );
endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker: one-hot grant and index of the next valid requester.
module uart_rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index,
    output logic               found
);
    pick_t pick;

    // Search from last_grant+1 with wrap; grant is empty when nothing is valid.
    always_comb begin
        pick  = rr_pick(MAX_REQ'(valid), MAX_IDX_W'(last_grant), NUM_REQ);
        found = pick.found;
        index = IDX_W'(pick.idx % NUM_REQ);
        grant = '0;
        if (pick.found) begin
            grant = NUM_REQ'(1) << index;
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among byte producers, with
// inter-frame gap enforcement and a watchdog on a transmitter that never completes.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   grant_id;
    logic [DATA_W-1:0]  tx_data;
    logic [WD_W-1:0]    wd_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               done_q;
    logic               done_rise;
    logic               timeout_hit;
    logic               gap_done;
    logic               accept;
    logic               timeout_err;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] rr_grant;
    logic [IDX_W-1:0]   rr_index;
    logic               rr_found;

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .valid      (bus.req_valid),
        .last_grant (last_grant),
        .grant      (rr_grant),
        .index      (rr_index),
        .found      (rr_found)
    );

    // tx_done is a level that can stay high, so completion is its rising edge.
    assign done_rise   = bus.tx_done & ~done_q;
    assign timeout_hit = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    // The gap only elapses on cycles where the transmitter has released done.
    assign gap_done    = ~bus.tx_done && (gap_cnt == GAP_W'(GAP_CYCLES - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the combinational accept handshake.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (!rst && rr_found) begin
                    req_ready  = rr_grant;
                    accept     = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (done_rise || timeout_hit) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (gap_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Byte latch, grant bookkeeping, counters, done edge detect and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data     <= '0;
            grant_id    <= '0;
            last_grant  <= IDX_W'(NUM_REQ - 1);
            wd_cnt      <= '0;
            gap_cnt     <= '0;
            done_q      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            done_q      <= bus.tx_done;
            // Done wins over a coinciding watchdog expiry.
            timeout_err <= (state == SEND) && timeout_hit && !done_rise;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_data    <= bus.req_data[rr_index*DATA_W +: DATA_W];
                        grant_id   <= rr_index;
                        last_grant <= rr_index;
                        wd_cnt     <= '0;
                    end
                end
                SEND: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (done_rise || timeout_hit) begin
                        gap_cnt <= '0;
                    end
                end
                GAP: begin
                    if (!bus.tx_done && !gap_done) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.tx_data     = tx_data;
    assign bus.tx_en       = (state == SEND);
    assign bus.grant_id    = grant_id;
    assign bus.busy        = (state != IDLE);
    assign bus.timeout_err = timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a scoreboard of expected grants.
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();
    uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus2 ();

    uart_tx_arbiter #(
        .NUM_REQ(NR), .DATA_W(DW), .GAP_CYCLES(16), .TIMEOUT_CYCLES(65535)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    uart_tx_arbiter #(
        .NUM_REQ(NR), .DATA_W(DW), .GAP_CYCLES(16), .TIMEOUT_CYCLES(100)
    ) dut_to (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [7:0] d);
        exp_t e;
        e.id   = 2'(id);
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic set_byte(input int i, input logic [7:0] d);
        bus.req_data[i*DW +: DW] = d;
    endtask

    // Wait (bounded) for tx_en, then compare the frame against the scoreboard head.
    task automatic wait_send(input string tag, output int waited);
        exp_t e;
        waited = 0;
        while (bus.tx_en !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_en_seen"}, 32'(bus.tx_en), 32'd1);
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s_sb: observed frame id=%0d data=%0h, expected no frame", tag, bus.grant_id, bus.tx_data);
        end else begin
            e = sb.pop_front();
            check({tag, "_data"}, 32'(bus.tx_data), 32'(e.data));
            check({tag, "_id"}, 32'(bus.grant_id), 32'(e.id));
        end
    endtask

    // Called on the first SEND cycle: complete after send_len cycles and check the gap.
    task automatic finish_frame(input string tag, input int send_len);
        int n;
        repeat (send_len - 1) @(negedge clk);
        bus.tx_done = 1'b1;
        @(negedge clk);
        check({tag, "_en_drop"}, 32'(bus.tx_en), 32'd0);
        bus.tx_done = 1'b0;
        n = 0;
        while (bus.busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_gap_len"}, 32'(n), 32'd16);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL tb_watchdog: observed no completion, expected finish within time limit");
        $fatal(1, "time limit");
    end

    initial begin
        int w;
        int n;
        int hi;
        int pulses;
        int b_low;
        int e_high;

        rst            = 1'b1;
        bus.req_valid  = '1;
        bus.req_data   = 32'hDEAD_BEEF;
        bus.tx_done    = 1'b0;
        bus2.req_valid = '0;
        bus2.req_data  = '0;
        bus2.tx_done   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state, with every requester valid.
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_tx_en", 32'(bus.tx_en), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_grant_id", 32'(bus.grant_id), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
        bus.req_valid = '0;
        bus.req_data  = '0;
        rst = 1'b0;
        @(negedge clk);

        // Single request on requester 2, done after 500 SEND cycles.
        set_byte(2, 8'h95);
        bus.req_valid = 4'b0100;
        push_exp(2, 8'h95);
        #1;
        check("t1_ready", 32'(bus.req_ready), 32'b0100);
        @(negedge clk);
        bus.req_valid = '0;
        check("t1_ready_off", 32'(bus.req_ready), 32'd0);
        wait_send("t1", w);
        check("t1_latency", 32'(w), 32'd0);
        repeat (499) @(negedge clk);
        check("t1_en_held", 32'(bus.tx_en), 32'd1);
        bus.tx_done = 1'b1;
        @(negedge clk);
        check("t1_en_drop", 32'(bus.tx_en), 32'd0);
        repeat (3) @(negedge clk);
        check("t1_busy_done_high", 32'(bus.busy), 32'd1);
        bus.tx_done = 1'b0;
        set_byte(2, 8'h96);
        bus.req_valid = 4'b0100;
        push_exp(2, 8'h96);
        n = 0;
        while (bus.req_ready === '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t1_gap_to_grant", 32'(n), 32'd16);
        @(negedge clk);
        bus.req_valid = '0;
        wait_send("t1b", w);
        finish_frame("t1b", 5);

        // Round robin with all four requesters continuously valid.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NR; i++) set_byte(i, 8'(8'h10 + i));
        bus.req_valid = 4'b1111;
        push_exp(0, 8'h10);
        push_exp(1, 8'h11);
        push_exp(2, 8'h12);
        push_exp(3, 8'h13);
        push_exp(0, 8'h10);
        #1;
        check("rr_first_ready", 32'(bus.req_ready), 32'b0001);
        for (int f = 0; f < 5; f++) begin
            wait_send($sformatf("rr%0d", f), w);
            if (f == 4) bus.req_valid = '0;
            finish_frame($sformatf("rr%0d", f), 3);
        end

        // Fairness after wrap: last_grant=3, requesters 1 and 3 valid.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_byte(1, 8'h21);
        set_byte(3, 8'h23);
        bus.req_valid = 4'b1010;
        push_exp(1, 8'h21);
        push_exp(3, 8'h23);
        push_exp(1, 8'h21);
        #1;
        check("fair_first_ready", 32'(bus.req_ready), 32'b0010);
        for (int f = 0; f < 3; f++) begin
            wait_send($sformatf("fair%0d", f), w);
            if (f == 2) bus.req_valid = '0;
            finish_frame($sformatf("fair%0d", f), 4);
        end

        // Sticky done: high from SEND entry and for 40 cycles after tx_en drops.
        set_byte(0, 8'h5A);
        bus.req_valid = 4'b0001;
        push_exp(0, 8'h5A);
        wait_send("sticky", w);
        bus.tx_done   = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        check("sticky_en_drop", 32'(bus.tx_en), 32'd0);
        b_low  = 0;
        e_high = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) b_low++;
            if (bus.tx_en !== 1'b0) e_high++;
        end
        check("sticky_busy_low_cycles", 32'(b_low), 32'd0);
        check("sticky_extra_en_cycles", 32'(e_high), 32'd0);
        bus.tx_done = 1'b0;
        n = 0;
        while (bus.busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("sticky_gap_len", 32'(n), 32'd16);
        check("sticky_sb_left", 32'(sb.size()), 32'd0);

        // Watchdog on the instance with TIMEOUT_CYCLES=100, tx_done held low.
        bus2.req_data[7:0] = 8'hA5;
        bus2.req_valid     = 4'b0001;
        #1;
        check("to_ready", 32'(bus2.req_ready), 32'b0001);
        n = 0;
        while (bus2.tx_en !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus2.req_valid = '0;
        check("to_en_seen", 32'(bus2.tx_en), 32'd1);
        check("to_tx_data", 32'(bus2.tx_data), 32'hA5);
        check("to_grant_id", 32'(bus2.grant_id), 32'd0);
        hi = 0;
        while (bus2.tx_en === 1'b1 && hi < 300) begin
            if (bus2.timeout_err !== 1'b0) hi = hi + 1000;
            hi++;
            @(negedge clk);
        end
        check("to_en_len", 32'(hi), 32'd100);
        check("to_pulse_at_drop", 32'(bus2.timeout_err), 32'd1);
        pulses = 0;
        n = 0;
        while (bus2.busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
            if (bus2.timeout_err !== 1'b0) pulses++;
        end
        check("to_gap_len", 32'(n), 32'd16);
        check("to_extra_pulses", 32'(pulses), 32'd0);

        // Reset 50 cycles into SEND; in-flight byte is dropped.
        set_byte(2, 8'h77);
        bus.req_valid = 4'b0100;
        n = 0;
        while (bus.tx_en !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_en_seen", 32'(bus.tx_en), 32'd1);
        bus.req_valid = '0;
        repeat (49) @(negedge clk);
        rst = 1'b1;
        set_byte(0, 8'h30);
        set_byte(1, 8'h31);
        set_byte(3, 8'h33);
        bus.req_valid = 4'b1011;
        @(negedge clk);
        check("mid_tx_en", 32'(bus.tx_en), 32'd0);
        check("mid_busy", 32'(bus.busy), 32'd0);
        check("mid_grant_id", 32'(bus.grant_id), 32'd0);
        check("mid_tx_data", 32'(bus.tx_data), 32'd0);
        check("mid_timeout_err", 32'(bus.timeout_err), 32'd0);
        check("mid_ready_in_rst", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;
        push_exp(0, 8'h30);
        #1;
        check("mid_first_ready", 32'(bus.req_ready), 32'b0001);
        wait_send("mid", w);
        bus.req_valid = '0;
        finish_frame("mid", 3);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
